// File: rtl/fifo_frame_drain.sv
// fifo_frame_drain
//
// Drains a single-clock byte FIFO and wraps the bytes into framed packets
// on a valid/ready byte stream: SOF byte, length byte, payload bytes and,
// when FRAME_DRAIN_CKSUM_EN is defined, a trailing XOR checksum byte.
// A frame starts once BURST_LEN bytes are buffered, or when a partial
// burst has been waiting for TIMEOUT cycles.
//
// Optional feature macro: FRAME_DRAIN_CKSUM_EN
//   defined   -> checksum byte (XOR of length and payload) ends each frame
//                and carries out_eop.
//   undefined -> no checksum logic; out_eop rides on the last payload byte.
//
// Ports:
//   clk           system clock, all logic on posedge
//   rst           synchronous active-high reset
//   buf_out       FIFO read data, valid the cycle after rd_en is sampled
//   buf_empty     FIFO empty flag
//   fifo_counter  FIFO occupancy
//   rd_en         FIFO read strobe, single-cycle pulses
//   out_data      framed byte stream
//   out_valid     out_data valid
//   out_ready     downstream accept
//   out_sop       high with the SOF byte
//   out_eop       high with the last byte of a frame
//   busy          high whenever the framer is not idle
//   frames_sent   count of completed frames, wraps at 16 bits

module fifo_frame_drain #(
    parameter int DATA_W                 = 8,
    parameter int CNT_W                  = 8,
    parameter int BURST_LEN              = 16,
    parameter int TIMEOUT                = 255,
    parameter logic [DATA_W-1:0] SOF     = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] buf_out,
    input  logic              buf_empty,
    input  logic [CNT_W-1:0]  fifo_counter,
    output logic              rd_en,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sop,
    output logic              out_eop,
    output logic              busy,
    output logic [15:0]       frames_sent
);

    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TMR_W-1:0]  TIMEOUT_T = TMR_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  BURST_CNT = CNT_W'(BURST_LEN);
    localparam logic [DATA_W-1:0] BURST_D   = DATA_W'(BURST_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LEN,
        S_RD,
        S_CAP,
        S_PAY
`ifdef FRAME_DRAIN_CKSUM_EN
        , S_CKS
`endif
    } state_t;

    state_t             state, state_n;
    logic [TMR_W-1:0]   timer, timer_n;
    logic [DATA_W-1:0]  len_q, len_n;
    logic [DATA_W-1:0]  remain, remain_n;
    logic [DATA_W-1:0]  data_n;
    logic               valid_n, sop_n, eop_n;
    logic [15:0]        frames_n;
    logic               start;
    logic               accept;
`ifdef FRAME_DRAIN_CKSUM_EN
    logic [DATA_W-1:0]  checksum, cks_n;
`endif

    assign accept = out_valid & out_ready;
    assign busy   = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            timer       <= '0;
            len_q       <= '0;
            remain      <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            out_sop     <= 1'b0;
            out_eop     <= 1'b0;
            frames_sent <= '0;
`ifdef FRAME_DRAIN_CKSUM_EN
            checksum    <= '0;
`endif
        end else begin
            state       <= state_n;
            timer       <= timer_n;
            len_q       <= len_n;
            remain      <= remain_n;
            out_data    <= data_n;
            out_valid   <= valid_n;
            out_sop     <= sop_n;
            out_eop     <= eop_n;
            frames_sent <= frames_n;
`ifdef FRAME_DRAIN_CKSUM_EN
            checksum    <= cks_n;
`endif
        end
    end

    // Output register next-values default to "hold", which keeps the stream
    // stable while a byte waits for out_ready.
    always_comb begin
        state_n  = state;
        timer_n  = timer;
        len_n    = len_q;
        remain_n = remain;
        data_n   = out_data;
        valid_n  = out_valid;
        sop_n    = out_sop;
        eop_n    = out_eop;
        frames_n = frames_sent;
        rd_en    = 1'b0;
        start    = 1'b0;
`ifdef FRAME_DRAIN_CKSUM_EN
        cks_n    = checksum;
`endif

        if (accept && out_eop) begin
            frames_n = frames_sent + 16'd1;
        end

        case (state)
            S_IDLE: begin
                if (buf_empty) begin
                    timer_n = '0;
                end else if (timer != TIMEOUT_T) begin
                    timer_n = timer + TMR_W'(1);
                end
                // A full burst wins over the timeout; the timeout path
                // snapshots whatever is buffered as the frame length.
                if (fifo_counter >= BURST_CNT) begin
                    len_n = BURST_D;
                    start = 1'b1;
                end else if ((timer == TIMEOUT_T) && !buf_empty) begin
                    len_n = DATA_W'(fifo_counter);
                    start = 1'b1;
                end
                if (start) begin
                    timer_n  = '0;
                    remain_n = len_n;
                    state_n  = S_HDR;
                    data_n   = SOF;
                    valid_n  = 1'b1;
                    sop_n    = 1'b1;
                    eop_n    = 1'b0;
                end
            end
            S_HDR: begin
                if (accept) begin
                    state_n = S_LEN;
                    data_n  = len_q;
                    sop_n   = 1'b0;
                end
            end
            S_LEN: begin
                if (accept) begin
                    state_n = S_RD;
                    valid_n = 1'b0;
`ifdef FRAME_DRAIN_CKSUM_EN
                    cks_n   = len_q;
`endif
                end
            end
            S_RD: begin
                // Gated by rst so no byte is popped on the reset edge.
                if (!buf_empty && !rst) begin
                    rd_en   = 1'b1;
                    state_n = S_CAP;
                end
            end
            S_CAP: begin
                data_n  = buf_out;
                valid_n = 1'b1;
                state_n = S_PAY;
`ifdef FRAME_DRAIN_CKSUM_EN
                cks_n   = checksum ^ buf_out;
                eop_n   = 1'b0;
`else
                eop_n   = (remain == DATA_W'(1));
`endif
            end
            S_PAY: begin
                if (accept) begin
                    remain_n = remain - DATA_W'(1);
                    if (remain != DATA_W'(1)) begin
                        state_n = S_RD;
                        valid_n = 1'b0;
                        eop_n   = 1'b0;
                    end else begin
`ifdef FRAME_DRAIN_CKSUM_EN
                        // checksum already folds in the byte being accepted.
                        state_n = S_CKS;
                        data_n  = checksum;
                        eop_n   = 1'b1;
`else
                        state_n = S_IDLE;
                        valid_n = 1'b0;
                        eop_n   = 1'b0;
`endif
                    end
                end
            end
`ifdef FRAME_DRAIN_CKSUM_EN
            S_CKS: begin
                if (accept) begin
                    state_n = S_IDLE;
                    valid_n = 1'b0;
                    eop_n   = 1'b0;
                end
            end
`endif
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_frame_drain.sv
// Testbench for fifo_frame_drain: a queue-based FIFO feeds the framer,
// expected frames are built by chunking the written byte list, and a
// negedge monitor scores every accepted output byte.

module tb_fifo_frame_drain;

    localparam int         BURST   = 16;
    localparam int         TIMEOUT = 255;
    localparam logic [7:0] SOF     = 8'hA5;

    typedef struct packed {
        logic [7:0] data;
        logic       sop;
        logic       eop;
    } beat_t;

    logic        clk          = 1'b0;
    logic        rst          = 1'b1;
    logic [7:0]  buf_out      = 8'h00;
    logic        buf_empty    = 1'b1;
    logic [7:0]  fifo_counter = 8'h00;
    logic        rd_en;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready    = 1'b1;
    logic        out_sop;
    logic        out_eop;
    logic        busy;
    logic [15:0] frames_sent;

    beat_t      exp_q[$];
    logic [7:0] fifo_q[$];
    logic [7:0] stim_q[$];
    logic       wr_en   = 1'b0;
    logic [7:0] wr_data = 8'h00;

    int    cyc = 0;
    int    rd_count = 0;
    int    n_checks = 0;
    int    n_fail = 0;
    int    frames_exp = 0;
    int    accepted_in_frame = 0;
    int    t_sop = 0;
    int    t_first_wr = 0;
    int    stall_seen = 0;
    int    stall_left = 0;
    logic  rand_ready = 1'b0;
    logic  stall_arm = 1'b0;
    logic  prev_stall = 1'b0;
    beat_t prev_beat;
    beat_t mon_e;

    always #5 clk = ~clk;

    fifo_frame_drain dut (
        .clk          (clk),
        .rst          (rst),
        .buf_out      (buf_out),
        .buf_empty    (buf_empty),
        .fifo_counter (fifo_counter),
        .rd_en        (rd_en),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sop      (out_sop),
        .out_eop      (out_eop),
        .busy         (busy),
        .frames_sent  (frames_sent)
    );

    // FIFO stand-in: registered read data, one write per cycle.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_en && fifo_q.size() > 0) begin
            buf_out  <= fifo_q.pop_front();
            rd_count <= rd_count + 1;
        end
        if (wr_en) fifo_q.push_back(wr_data);
        buf_empty    <= (fifo_q.size() == 0);
        fifo_counter <= 8'(fifo_q.size());
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, actual, expected);
        end
    endtask

    // Reference: the written bytes drain in order as BURST-sized frames,
    // with any remainder sent as one short (timeout) frame.
    task automatic modelFrames();
        int         pos;
        int         n;
        logic [7:0] b;
`ifdef FRAME_DRAIN_CKSUM_EN
        logic [7:0] cks;
`endif
        pos = 0;
        while (pos < stim_q.size()) begin
            n = stim_q.size() - pos;
            if (n > BURST) n = BURST;
            exp_q.push_back('{data: SOF, sop: 1'b1, eop: 1'b0});
            exp_q.push_back('{data: 8'(n), sop: 1'b0, eop: 1'b0});
`ifdef FRAME_DRAIN_CKSUM_EN
            cks = 8'(n);
`endif
            for (int i = 0; i < n; i++) begin
                b = stim_q[pos + i];
`ifdef FRAME_DRAIN_CKSUM_EN
                cks = cks ^ b;
                exp_q.push_back('{data: b, sop: 1'b0, eop: 1'b0});
`else
                exp_q.push_back('{data: b, sop: 1'b0, eop: (i == n - 1)});
`endif
            end
`ifdef FRAME_DRAIN_CKSUM_EN
            exp_q.push_back('{data: cks, sop: 1'b0, eop: 1'b1});
`endif
            pos += n;
            frames_exp++;
        end
    endtask

    task automatic applyStimulus();
        modelFrames();
        for (int i = 0; i < stim_q.size(); i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_data = stim_q[i];
            if (i == 0) t_first_wr = cyc + 1;
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic drainWait(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, (exp_q.size() != 0 || busy), 0);
    endtask

    // out_ready driver, with a one-shot 5-cycle stall on payload byte 0x05.
    initial forever begin
        @(posedge clk);
        #1;
        if (stall_arm && out_valid && !out_sop && out_data == 8'h05) begin
            stall_arm  = 1'b0;
            stall_left = 5;
        end
        if (stall_left > 0) begin
            out_ready  = 1'b0;
            stall_left = stall_left - 1;
        end else if (rand_ready) begin
            out_ready = ($urandom_range(0, 3) != 0);
        end else begin
            out_ready = 1'b1;
        end
    end

    // Monitor: scores accepted bytes and checks stream rules every cycle.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            prev_stall        = 1'b0;
            accepted_in_frame = 0;
        end else begin
            checkOutput("rd_en_on_empty", rd_en & buf_empty, 0);
            checkOutput("rd_en_with_pending_byte", rd_en & out_valid, 0);
            if (prev_stall) begin
                checkOutput("held_valid", out_valid, 1);
                checkOutput("held_data", out_data, prev_beat.data);
                checkOutput("held_sop", out_sop, prev_beat.sop);
                checkOutput("held_eop", out_eop, prev_beat.eop);
            end
            if (out_valid && !out_ready && !out_sop && out_data == 8'h05) stall_seen++;
            if (out_valid && out_ready) begin
                checkOutput("beat_expected", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    checkOutput("out_data", out_data, mon_e.data);
                    checkOutput("out_sop", out_sop, mon_e.sop);
                    checkOutput("out_eop", out_eop, mon_e.eop);
                end
                if (out_sop) begin
                    t_sop             = cyc;
                    accepted_in_frame = 1;
                end else begin
                    accepted_in_frame++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_beat  = '{data: out_data, sop: out_sop, eop: out_eop};
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: actual timeout required completion");
        $fatal(1, "[TB] simulation watchdog expired");
    end

    initial begin
        int rd0;
        int n;
        int k;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_rd_en", rd_en, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_out_sop", out_sop, 0);
        checkOutput("reset_out_eop", out_eop, 0);
        checkOutput("reset_out_data", out_data, 0);
        checkOutput("reset_frames_sent", frames_sent, 0);
        @(negedge clk);
        rst = 1'b0;

        // Full burst 0x01..0x10, out_ready held high.
        $display("[TB] full burst frame");
        stim_q.delete();
        for (int i = 1; i <= 16; i++) stim_q.push_back(8'(i));
        rd0 = rd_count;
        applyStimulus();
        drainWait("drain_burst", 1000);
        checkOutput("burst_rd_pulses", rd_count - rd0, 16);
        checkOutput("burst_frames_sent", frames_sent, 16'(frames_exp));

        // Short frame via timeout.
        $display("[TB] timeout frame");
        stim_q = '{8'hAA, 8'hBB, 8'hCC};
        applyStimulus();
        drainWait("drain_timeout", 1000);
        checkOutput("timeout_not_early", (t_sop - t_first_wr >= TIMEOUT), 1);
        checkOutput("timeout_not_late", (t_sop - t_first_wr <= TIMEOUT + 8), 1);
        checkOutput("timeout_fifo_empty", buf_empty, 1);
        checkOutput("timeout_frames_sent", frames_sent, 16'(frames_exp));

        // Backpressure on payload byte 0x05.
        $display("[TB] backpressure frame");
        stim_q.delete();
        for (int i = 1; i <= 16; i++) stim_q.push_back(8'(i));
        stall_seen = 0;
        stall_arm  = 1'b1;
        rd0 = rd_count;
        applyStimulus();
        drainWait("drain_stall", 1000);
        checkOutput("stall_cycles_on_05", stall_seen, 5);
        checkOutput("stall_rd_pulses", rd_count - rd0, 16);
        checkOutput("stall_frames_sent", frames_sent, 16'(frames_exp));

        // 40 bytes: two full bursts and an 8-byte timeout frame.
        $display("[TB] 40-byte stream");
        stim_q.delete();
        for (int i = 0; i < 40; i++) stim_q.push_back(8'(i));
        applyStimulus();
        drainWait("drain_40", 2000);
        checkOutput("forty_frames_sent", frames_sent, 16'(frames_exp));
        checkOutput("forty_fifo_empty", buf_empty, 1);

        // Reset in the middle of a payload.
        $display("[TB] reset mid-frame");
        stim_q.delete();
        for (int i = 0; i < 16; i++) stim_q.push_back(8'($urandom));
        applyStimulus();
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (!(out_valid && !out_sop && accepted_in_frame >= 7) && n < 1000);
        checkOutput("reset_trigger_reached", (n >= 1000), 0);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("midreset_out_valid", out_valid, 0);
        checkOutput("midreset_rd_en", rd_en, 0);
        checkOutput("midreset_busy", busy, 0);
        checkOutput("midreset_frames_sent", frames_sent, 0);
        frames_exp = 0;
        stim_q = fifo_q;
        modelFrames();
        drainWait("drain_after_reset", 1500);
        checkOutput("after_reset_frames_sent", frames_sent, 16'(frames_exp));

        // Random bursts with random backpressure.
        $display("[TB] random bursts");
        rand_ready = 1'b1;
        for (int it = 0; it < 4; it++) begin
            k = $urandom_range(1, 40);
            stim_q.delete();
            for (int i = 0; i < k; i++) stim_q.push_back(8'($urandom));
            rd0 = rd_count;
            applyStimulus();
            drainWait("drain_random", 3000);
            checkOutput("random_rd_pulses", rd_count - rd0, k);
            checkOutput("random_frames_sent", frames_sent, 16'(frames_exp));
        end
        rand_ready = 1'b0;

        repeat (300) @(negedge clk);
        checkOutput("final_busy", busy, 0);
        checkOutput("final_fifo_empty", buf_empty, 1);
        checkOutput("final_scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
